// File: rtl/n2t_pkg.sv
// ---------------------------------------------------------------------------
// n2t_pkg
// Shared types and constants for the 8-word RAM burst front-end.
//   burst_state_t : sequencer state encoding (IDLE, WRITE, READ, DONE)
//   OP_WRITE/OP_READ : command opcode values carried on cmd_op
//   RAM8_DEPTH    : number of words in the downstream RAM
// ---------------------------------------------------------------------------
package n2t_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } burst_state_t;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

    localparam int RAM8_DEPTH = 8;

endpackage : n2t_pkg

// File: rtl/ram_8_burst_port_if.sv
// ---------------------------------------------------------------------------
// ram_8_burst_port_if
// Bundles every handshake and RAM-side signal of the burst front-end.
//   cmd_*  : burst command channel (valid/ready), op/base/count payload
//   wr_*   : write-word stream into the block (valid/ready)
//   rd_*   : read-word stream out of the block (valid/ready)
//   ram_*  : drive/observe the 8-word RAM (in, address, load, out)
//   busy   : sequencer not idle
//   done   : one-cycle pulse at the end of each burst
// Modports:
//   slave  : the burst front-end itself
//   master : the command issuer / data producer / consumer / RAM model
// ---------------------------------------------------------------------------
interface ram_8_burst_port_if #(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 3
);

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_op;
    logic [ADDR_BITS-1:0] cmd_base;
    logic [ADDR_BITS:0]   cmd_count;

    logic [WIDTH-1:0]     wr_data;
    logic                 wr_valid;
    logic                 wr_ready;

    logic [WIDTH-1:0]     rd_data;
    logic                 rd_valid;
    logic                 rd_ready;

    logic [WIDTH-1:0]     ram_in;
    logic [ADDR_BITS-1:0] ram_address;
    logic                 ram_load;
    logic [WIDTH-1:0]     ram_out;

    logic                 busy;
    logic                 done;

    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_count,
        input  wr_data, wr_valid,
        input  rd_ready,
        input  ram_out,
        output cmd_ready,
        output wr_ready,
        output rd_data, rd_valid,
        output ram_in, ram_address, ram_load,
        output busy, done
    );

    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_count,
        output wr_data, wr_valid,
        output rd_ready,
        output ram_out,
        input  cmd_ready,
        input  wr_ready,
        input  rd_data, rd_valid,
        input  ram_in, ram_address, ram_load,
        input  busy, done
    );

endinterface : ram_8_burst_port_if

// File: rtl/ram_8_burst_port.sv
// ---------------------------------------------------------------------------
// ram_8_burst_port
// Burst sequencer sitting directly in front of an 8-word RAM. Accepts a
// command (op, base, count), then streams count words into consecutive
// RAM locations (write) or out of them (read), wrapping modulo the depth.
// Counts above the depth clamp to the depth; a zero count goes straight
// to the one-cycle DONE state.
//
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high; aborts any burst without a done pulse
//   bus   : ram_8_burst_port_if.slave (command, write, read, RAM, status)
//
// The RAM read path is combinational (ram_out follows ram_address), so
// rd_data is presented in the same cycle the address is, and stays stable
// while the consumer stalls because the address register only moves on a
// completed handshake.
// ---------------------------------------------------------------------------
module ram_8_burst_port
    import n2t_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ADDR_BITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    ram_8_burst_port_if.slave     bus
);

    localparam int                   DEPTH     = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0]   MAX_COUNT = (ADDR_BITS + 1)'(DEPTH);
    localparam logic [ADDR_BITS:0]   CNT_ZERO  = (ADDR_BITS + 1)'(0);
    localparam logic [ADDR_BITS:0]   CNT_ONE   = (ADDR_BITS + 1)'(1);
    localparam logic [ADDR_BITS-1:0] ADDR_ZERO = ADDR_BITS'(0);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE  = ADDR_BITS'(1);

    burst_state_t         state_q, state_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS:0]   remaining_q, remaining_d;

    logic [ADDR_BITS:0]   count_clamped_s;
    logic [WIDTH-1:0]     wr_word_s;
    logic                 wr_hs_s;
    logic                 rd_hs_s;

    // Clamp oversize counts to one full pass over the RAM.
    always_comb begin
        count_clamped_s = bus.cmd_count;
        if (bus.cmd_count > MAX_COUNT) begin
            count_clamped_s = MAX_COUNT;
        end else begin
            count_clamped_s = bus.cmd_count;
        end
    end

    // Handshake qualifiers; only meaningful in their own state, so stray
    // wr_valid / rd_ready activity elsewhere is ignored.
    assign wr_hs_s = (state_q == WRITE) && bus.wr_valid;
    assign rd_hs_s = (state_q == READ)  && bus.rd_ready;

    // Next-state logic for the burst sequencer and its address/count.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d      = bus.cmd_base;
                    remaining_d = count_clamped_s;
                    if (count_clamped_s == CNT_ZERO) begin
                        state_d = DONE;
                    end else if (bus.cmd_op == OP_READ) begin
                        state_d = READ;
                    end else begin
                        state_d = WRITE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (wr_hs_s) begin
                    // Address wraps naturally at the register width.
                    addr_d      = addr_q + ADDR_ONE;
                    remaining_d = remaining_q - CNT_ONE;
                    if (remaining_q == CNT_ONE) begin
                        state_d = DONE;
                    end else begin
                        state_d = WRITE;
                    end
                end else begin
                    state_d = WRITE;
                end
            end
            READ: begin
                if (rd_hs_s) begin
                    addr_d      = addr_q + ADDR_ONE;
                    remaining_d = remaining_q - CNT_ONE;
                    if (remaining_q == CNT_ONE) begin
                        state_d = DONE;
                    end else begin
                        state_d = READ;
                    end
                end else begin
                    state_d = READ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d     = IDLE;
                addr_d      = ADDR_ZERO;
                remaining_d = CNT_ZERO;
            end
        endcase
    end

    // State, address and remaining-count registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= ADDR_ZERO;
            remaining_q <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
        end
    end

    // Outputs are gated by reset so a mid-burst reset cycle shows the idle
    // handshake picture and, critically, never issues a RAM load.
    assign wr_word_s       = bus.wr_data;
    assign bus.ram_in      = wr_word_s;
    assign bus.ram_address = addr_q;
    assign bus.ram_load    = wr_hs_s && !reset;
    assign bus.rd_data     = bus.ram_out;

    assign bus.cmd_ready   = (state_q == IDLE)  && !reset;
    assign bus.wr_ready    = (state_q == WRITE) && !reset;
    assign bus.rd_valid    = (state_q == READ)  && !reset;
    assign bus.done        = (state_q == DONE)  && !reset;
    assign bus.busy        = (state_q != IDLE)  && !reset;

endmodule : ram_8_burst_port

// File: tb/tb_ram_8_burst_port.sv
// ---------------------------------------------------------------------------
// tb_ram_8_burst_port
// Directed bench for the burst front-end. An 8-word RAM model with a
// combinational read port hangs off the ram_* signals. Inputs are driven
// 1 time unit after the rising edge and outputs sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_ram_8_burst_port;
    import n2t_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    ram_8_burst_port_if #(.WIDTH(16), .ADDR_BITS(3)) bus ();

    ram_8_burst_port #(.WIDTH(16), .ADDR_BITS(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Downstream 8-word RAM: synchronous write, combinational read.
    logic [15:0] mem [RAM8_DEPTH];
    always @(posedge clock) begin
        if (bus.ram_load) mem[bus.ram_address] <= bus.ram_in;
    end
    assign bus.ram_out = mem[bus.ram_address];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [15:0] d4 [4];
    initial begin
        d4[0] = 16'h1111; d4[1] = 16'h2222; d4[2] = 16'h3333; d4[3] = 16'h4444;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic op, input logic [2:0] base, input logic [3:0] cnt);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_base  = base;
        bus.cmd_count = cnt;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        send_cmd(OP_WRITE, 3'd5, 4'd3);
        bus.wr_valid = 1'b1; bus.rd_ready = 1'b1; bus.wr_data = 16'hFFFF;
        tick(); tick();
        checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=0", bus.cmd_ready); end
        checks++; if (bus.ram_load !== 1'b0) begin failures++; $display("FAIL rst_ram_load got=%b exp=0", bus.ram_load); end
        checks++; if ({bus.wr_ready, bus.rd_valid, bus.done, bus.busy} !== 4'b0000) begin failures++; $display("FAIL rst_status got=%b exp=0000", {bus.wr_ready, bus.rd_valid, bus.done, bus.busy}); end
        checks++; if (bus.ram_address !== 3'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", bus.ram_address); end
        bus.cmd_valid = 1'b0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL rst_release got=%b%b exp=10", bus.cmd_ready, bus.busy); end
    endtask

    task automatic test_write_wrap();
        logic [2:0] ea;
        send_cmd(OP_WRITE, 3'd6, 4'd4);
        bus.wr_valid = 1'b1; bus.wr_data = d4[0];
        #1;
        checks++; if (bus.cmd_ready !== 1'b1 || bus.ram_load !== 1'b0) begin failures++; $display("FAIL wr_accept got=%b%b exp=10", bus.cmd_ready, bus.ram_load); end
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.wr_data = d4[k];
            ea = 3'(6 + k);
            #1;
            checks++; if (bus.ram_load !== 1'b1 || bus.ram_address !== ea) begin failures++; $display("FAIL wr_beat%0d got load=%b addr=%0d exp load=1 addr=%0d", k, bus.ram_load, bus.ram_address, ea); end
            tick();
        end
        #1;
        checks++; if (bus.done !== 1'b1 || bus.ram_load !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL wr_done got=%b%b%b exp=101", bus.done, bus.ram_load, bus.busy); end
        bus.wr_valid = 1'b0;
        tick();
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL wr_idle got=%b%b%b exp=001", bus.done, bus.busy, bus.cmd_ready); end
        checks++; if (mem[6] !== 16'h1111 || mem[7] !== 16'h2222 || mem[0] !== 16'h3333 || mem[1] !== 16'h4444) begin failures++; $display("FAIL wr_mem got=%h %h %h %h exp=1111 2222 3333 4444", mem[6], mem[7], mem[0], mem[1]); end
    endtask

    task automatic test_read_wrap();
        send_cmd(OP_READ, 3'd6, 4'd4);
        bus.rd_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== d4[k]) begin failures++; $display("FAIL rd_beat%0d got valid=%b data=%h exp valid=1 data=%h", k, bus.rd_valid, bus.rd_data, d4[k]); end
            tick();
        end
        #1;
        checks++; if (bus.done !== 1'b1 || bus.rd_valid !== 1'b0) begin failures++; $display("FAIL rd_done got=%b%b exp=10", bus.done, bus.rd_valid); end
        bus.rd_ready = 1'b0;
        tick();
        checks++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rd_idle got=%b%b exp=01", bus.done, bus.cmd_ready); end
    endtask

    task automatic test_read_stall();
        send_cmd(OP_READ, 3'd6, 4'd4);
        bus.rd_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        #1;
        checks++; if (bus.rd_data !== 16'h1111) begin failures++; $display("FAIL st_first got=%h exp=1111", bus.rd_data); end
        tick();
        bus.rd_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'h2222 || bus.ram_address !== 3'd7) begin failures++; $display("FAIL st_hold%0d got valid=%b data=%h addr=%0d exp valid=1 data=2222 addr=7", s, bus.rd_valid, bus.rd_data, bus.ram_address); end
            tick();
        end
        bus.rd_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            #1;
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== d4[k]) begin failures++; $display("FAIL st_beat%0d got valid=%b data=%h exp valid=1 data=%h", k, bus.rd_valid, bus.rd_data, d4[k]); end
            tick();
        end
        #1;
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL st_done got=%b exp=1", bus.done); end
        bus.rd_ready = 1'b0;
        tick();
    endtask

    task automatic test_count_edges();
        logic [2:0]  ea;
        logic [15:0] ed;
        send_cmd(OP_WRITE, 3'd2, 4'd0);
        bus.wr_valid = 1'b1; bus.wr_data = 16'hDEAD;
        tick();
        bus.cmd_valid = 1'b0;
        #1;
        checks++; if (bus.done !== 1'b1 || bus.ram_load !== 1'b0 || bus.wr_ready !== 1'b0) begin failures++; $display("FAIL c0_done got=%b%b%b exp=100", bus.done, bus.ram_load, bus.wr_ready); end
        tick();
        checks++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.ram_load !== 1'b0) begin failures++; $display("FAIL c0_idle got=%b%b%b exp=010", bus.done, bus.cmd_ready, bus.ram_load); end
        send_cmd(OP_WRITE, 3'd3, 4'd12);
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.wr_data = 16'(32'hB000 + k);
            ea = 3'(3 + k);
            #1;
            checks++; if (bus.ram_load !== 1'b1 || bus.ram_address !== ea) begin failures++; $display("FAIL c12_beat%0d got load=%b addr=%0d exp load=1 addr=%0d", k, bus.ram_load, bus.ram_address, ea); end
            tick();
        end
        #1;
        checks++; if (bus.done !== 1'b1 || bus.ram_load !== 1'b0) begin failures++; $display("FAIL c12_done got=%b%b exp=10", bus.done, bus.ram_load); end
        bus.wr_valid = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            ea = 3'(3 + k);
            ed = 16'(32'hB000 + k);
            checks++; if (mem[ea] !== ed) begin failures++; $display("FAIL c12_mem%0d got=%h exp=%h", ea, mem[ea], ed); end
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] ed;
        send_cmd(OP_WRITE, 3'd0, 4'd8);
        bus.wr_valid = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.wr_data = 16'(32'hC000 + k);
            tick();
        end
        bus.wr_data = 16'hCCCC;
        reset = 1'b1;
        #1;
        checks++; if (bus.ram_load !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL ab_rstcycle got=%b%b%b exp=000", bus.ram_load, bus.done, bus.busy); end
        tick();
        reset = 1'b0;
        #1;
        checks++; if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.ram_load !== 1'b0) begin failures++; $display("FAIL ab_after got=%b%b%b exp=100", bus.cmd_ready, bus.done, bus.ram_load); end
        bus.wr_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            ed = (j < 3) ? 16'(32'hC000 + j) : 16'(32'hB000 + j - 3);
            checks++; if (mem[j] !== ed) begin failures++; $display("FAIL ab_mem%0d got=%h exp=%h", j, mem[j], ed); end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        send_cmd(OP_WRITE, 3'd4, 4'd2);
        bus.wr_valid = 1'b1; bus.wr_data = 16'hD001;
        #1;
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL bb_accept1 got=%b exp=1", bus.cmd_ready); end
        tick();
        send_cmd(OP_READ, 3'd4, 4'd2);
        #1;
        checks++; if (bus.ram_load !== 1'b1 || bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL bb_w0 got=%b%b exp=10", bus.ram_load, bus.cmd_ready); end
        tick();
        bus.wr_data = 16'hD002;
        #1;
        checks++; if (bus.ram_load !== 1'b1 || bus.ram_address !== 3'd5) begin failures++; $display("FAIL bb_w1 got load=%b addr=%0d exp load=1 addr=5", bus.ram_load, bus.ram_address); end
        tick();
        #1;
        checks++; if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b0 || bus.ram_load !== 1'b0) begin failures++; $display("FAIL bb_done got=%b%b%b exp=100", bus.done, bus.cmd_ready, bus.ram_load); end
        tick();
        checks++; if (bus.cmd_ready !== 1'b1 || bus.ram_load !== 1'b0) begin failures++; $display("FAIL bb_accept2 got=%b%b exp=10", bus.cmd_ready, bus.ram_load); end
        tick();
        bus.cmd_valid = 1'b0;
        bus.rd_ready  = 1'b1;
        #1;
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 16'hD001 || bus.ram_load !== 1'b0) begin failures++; $display("FAIL bb_r0 got valid=%b data=%h load=%b exp 1 d001 0", bus.rd_valid, bus.rd_data, bus.ram_load); end
        tick();
        checks++; if (bus.rd_data !== 16'hD002 || bus.ram_load !== 1'b0) begin failures++; $display("FAIL bb_r1 got data=%h load=%b exp d002 0", bus.rd_data, bus.ram_load); end
        tick();
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL bb_done2 got=%b exp=1", bus.done); end
        bus.rd_ready = 1'b0; bus.wr_valid = 1'b0;
        tick();
        checks++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("FAIL bb_idle got=%b%b exp=10", bus.cmd_ready, bus.busy); end
    endtask

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_base = 3'd0; bus.cmd_count = 4'd0;
        bus.wr_valid = 1'b0; bus.wr_data = 16'h0000; bus.rd_ready = 1'b0;
        test_reset();
        test_write_wrap();
        test_read_wrap();
        test_read_stall();
        test_count_edges();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ram_8_burst_port
